// File: rtl/conv_pkg.sv
// Shared types and constants for the vertical-edge (Sobel Gx) convolution block.
//   PIX_W   : grayscale pixel width
//   COORD_W : x/y coordinate width
//   PIX_MAX : saturation ceiling of the edge magnitude
//   col_t   : one 3-pixel window column (top = row y-2, mid = row y-1, bot = row y)
package conv_pkg;

  localparam int unsigned PIX_W   = 12;
  localparam int unsigned COORD_W = 11;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t PIX_MAX = 12'hFFF;

  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } col_t;

  // Weighted column sum top + 2*mid + bot; at most 4*4095 = 16380, fits in 14 bits.
  function automatic logic [13:0] col_sum(input col_t c);
    return {2'b00, c.top} + {1'b0, c.mid, 1'b0} + {2'b00, c.bot};
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row line buffer: combinational read and synchronous write at the same address.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : read/write column address
//   wdata_i : data written on the rising edge when we_i is high
//   rdata_o : current contents at addr_i (old value during a write cycle)
// Contents are not reset; the caller masks stale data.
module line_buffer #(
  parameter int unsigned Depth = 1280,
  parameter int unsigned Width = 12,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/convolution_vertical.sv
// Streaming 3x3 Sobel Gx vertical-edge detector on a raster-order 12-bit grayscale stream.
//   iCLK, iRST            : clock, asynchronous active-high reset
//   iX_Cont, iY_Cont      : column/row of iDATA
//   iDATA, iDVAL          : input pixel and its valid strobe
//   oRed, oGreen, oBlue   : saturated |Gx| for window centre (x-1, y-1), identical values
//   oDVAL                 : one output per accepted pixel, one clock after it was sampled
module convolution_vertical
  import conv_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 1280
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic [PIX_W-1:0]   iDATA,
  input  logic               iDVAL,
  output logic [PIX_W-1:0]   oRed,
  output logic [PIX_W-1:0]   oGreen,
  output logic [PIX_W-1:0]   oBlue,
  output logic               oDVAL
);

  localparam int unsigned AddrW = $clog2(MAX_WIDTH);

  logic             in_range;
  logic [AddrW-1:0] lb_addr;
  logic             lb_we;
  pix_t             lb1_rdata;
  pix_t             lb2_rdata;
  col_t             col_new;

  col_t w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic border_q, border_d;
  logic v1_q, v1_d;
  pix_t pix_q, pix_d;
  logic dval_q, dval_d;

  logic signed [14:0] gx;
  logic        [14:0] mag_wide;
  pix_t               mag;

  // Out-of-range columns still flow through the window but never touch the buffers.
  assign in_range = 32'(iX_Cont) < MAX_WIDTH;
  assign lb_addr  = in_range ? AddrW'(iX_Cont) : '0;
  assign lb_we    = iDVAL && in_range;

  // lb1 holds row y-1; on write its old value cascades into lb2 (row y-2).
  line_buffer #(
    .Depth (MAX_WIDTH),
    .Width (PIX_W)
  ) u_lb1 (
    .clk_i   (iCLK),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (iDATA),
    .rdata_o (lb1_rdata)
  );

  line_buffer #(
    .Depth (MAX_WIDTH),
    .Width (PIX_W)
  ) u_lb2 (
    .clk_i   (iCLK),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (lb1_rdata),
    .rdata_o (lb2_rdata)
  );

  assign col_new = '{top: lb2_rdata, mid: lb1_rdata, bot: iDATA};

  // Middle column carries zero weight in Gx.
  always_comb begin
    gx       = $signed({1'b0, col_sum(w2_q)}) - $signed({1'b0, col_sum(w0_q)});
    mag_wide = gx[14] ? 15'(-gx) : 15'(gx);
    mag      = (mag_wide > 15'(PIX_MAX)) ? PIX_MAX : mag_wide[PIX_W-1:0];
  end

  always_comb begin
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    border_d = border_q;
    v1_d     = iDVAL;
    if (iDVAL) begin
      w0_d     = w1_q;
      w1_d     = w2_q;
      w2_d     = col_new;
      border_d = (iX_Cont >= COORD_W'(2)) && (iY_Cont >= COORD_W'(2)) && in_range;
    end

    // Colour outputs hold their last value across invalid cycles.
    pix_d  = pix_q;
    dval_d = v1_q;
    if (v1_q) begin
      pix_d = border_q ? mag : '0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      w0_q     <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
      border_q <= 1'b0;
      v1_q     <= 1'b0;
      pix_q    <= '0;
      dval_q   <= 1'b0;
    end else begin
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      border_q <= border_d;
      v1_q     <= v1_d;
      pix_q    <= pix_d;
      dval_q   <= dval_d;
    end
  end

  assign oRed   = pix_q;
  assign oGreen = pix_q;
  assign oBlue  = pix_q;
  assign oDVAL  = dval_q;

endmodule

// File: tb/tb_convolution_vertical.sv
// Directed bench for convolution_vertical: 6x6 step, ramp and uniform frames, blanking gaps,
// out-of-range column, and reset behaviour (idle and mid-frame).
module tb_convolution_vertical;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [10:0] iX_Cont = '0;
  logic [10:0] iY_Cont = '0;
  logic [11:0] iDATA = '0;
  logic        iDVAL = 1'b0;
  logic [11:0] oRed, oGreen, oBlue;
  logic        oDVAL;

  convolution_vertical #(
    .MAX_WIDTH (1280)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .oRed    (oRed),
    .oGreen  (oGreen),
    .oBlue   (oBlue),
    .oDVAL   (oDVAL)
  );

  always #5 iCLK = ~iCLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned out_cnt = 0;

  // Expected output for the pixel currently driven, and its two-edge delay line.
  logic [11:0] exp_in = '0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [11:0] s1_e = '0, s2_e = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= iDVAL;
      s1_e <= exp_in;
      s2_v <= s1_v;
      s2_e <= s1_e;
    end
  end

  always @(negedge iCLK) begin
    check("dval", {31'b0, oDVAL}, {31'b0, s2_v});
    if (oDVAL === 1'b1) out_cnt++;
    if (oDVAL === 1'b1 && s2_v) begin
      check("pix", {20'b0, oRed}, {20'b0, s2_e});
      check("green", {20'b0, oGreen}, {20'b0, oRed});
      check("blue", {20'b0, oBlue}, {20'b0, oRed});
    end
  end

  // kind 0: columns 2,3 = FFF; kind 1: ramp 0x010*x; kind 2: uniform 0x7FF.
  function automatic logic [11:0] pixval(input int kind, input int x);
    case (kind)
      0:       return (x == 2 || x == 3) ? 12'hFFF : 12'h000;
      1:       return 12'(16 * x);
      default: return 12'h7FF;
    endcase
  endfunction

  function automatic logic [11:0] expval(input int kind, input int x, input int y);
    if (y < 2 || x < 2) return 12'h000;
    case (kind)
      0:       return 12'hFFF;
      1:       return 12'h080;
      default: return 12'h000;
    endcase
  endfunction

  task automatic drive_px(input int x, input int y, input logic [11:0] d, input logic [11:0] e);
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    iDATA   = d;
    exp_in  = e;
    iDVAL   = 1'b1;
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    iDATA = 12'($urandom);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic send_frame(input int kind, input bit gaps, input string tag);
    int unsigned start;
    start = out_cnt;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 6; x++) begin
        if (gaps && x == 3) idle(3);
        drive_px(x, y, pixval(kind, x), expval(kind, x, y));
      end
      if (gaps && y < 5) idle(5);
    end
    idle(3);
    check(tag, out_cnt - start, 36);
  endtask

  initial begin
    int unsigned start;

    // Reset held with iDVAL toggling.
    #1 iRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iDVAL = ~iDVAL;
      @(negedge iCLK);
      check("rst_dval", {31'b0, oDVAL}, 32'd0);
      check("rst_red", {20'b0, oRed}, 32'd0);
    end
    @(posedge iCLK);
    #1;
    iRST  = 1'b0;
    iDVAL = 1'b0;

    // First pixel: oDVAL one edge after it is sampled.
    drive_px(0, 0, 12'h000, 12'h000);
    iDVAL = 1'b0;
    @(negedge iCLK);
    check("lat_before", {31'b0, oDVAL}, 32'd0);
    @(negedge iCLK);
    check("lat_first", {31'b0, oDVAL}, 32'd1);
    idle(2);

    send_frame(0, 1'b0, "step_cnt");
    send_frame(1, 1'b0, "ramp_cnt");
    send_frame(2, 1'b0, "flat_cnt");
    send_frame(1, 1'b1, "gap_cnt");

    // Column beyond the buffer depth: still one valid output, masked to zero.
    start = out_cnt;
    drive_px(1280, 5, 12'hFFF, 12'h000);
    idle(3);
    check("oob_cnt", out_cnt - start, 1);

    // Reset mid-row 3: the pixel sampled just before reset must never appear.
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 6; x++) drive_px(x, y, pixval(1, x), expval(1, x, y));
    end
    for (int x = 0; x < 3; x++) drive_px(x, 3, pixval(1, x), expval(1, x, 3));
    iRST  = 1'b1;
    iDVAL = 1'b0;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(negedge iCLK);
    check("rst_drop", {31'b0, oDVAL}, 32'd0);
    idle(2);
    send_frame(1, 1'b0, "restart_cnt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
